echo_tone_mapper: RTL

//  Consumes the 32-bit echo pulse-width count from the HC-SR04 measurement stage (50 MHz clk cycles).

---
 rtl/echo_tone_mapper_pkg.sv | 33 +++
 rtl/echo_tone_mapper_tone_gen.sv | 47 ++++
 rtl/echo_tone_mapper.sv | 132 +++++++++++++
 3 files changed

// File: rtl/echo_tone_mapper_pkg.sv
// Shared definitions for the theremin echo-to-tone mapper: widths, defaults,
// FSM encoding and the count-to-half-period mapping.
package echo_tone_mapper_pkg;

  localparam int unsigned CLK_HZ          = 50_000_000;
  localparam int unsigned CNT_W           = 32;
  localparam int unsigned HP_W            = 20;
  localparam int unsigned DEF_MIN_CNT     = 5800;
  localparam int unsigned DEF_MAX_CNT     = 145000;
  localparam int unsigned DEF_BASE_HP     = 25000;
  localparam int unsigned DEF_SHIFT       = 2;
  localparam int unsigned DEF_OOR_LIMIT   = 3;
  localparam int unsigned DEF_TIMEOUT     = 5_000_000;

  typedef enum logic {
    ST_MUTED   = 1'b0,
    ST_PLAYING = 1'b1
  } state_e;

  // Linear map avg -> half-period, computed at full width and saturated to
  // the tone counter range. Averages below min_cnt pin to base_hp.
  function automatic logic [HP_W-1:0] map_hp(input logic [CNT_W+1:0] avg,
                                             input logic [CNT_W+1:0] min_cnt,
                                             input logic [CNT_W+1:0] base_hp,
                                             input int unsigned      shift);
    logic [CNT_W+1:0] full;
    if (avg <= min_cnt) full = base_hp;
    else                full = base_hp + ((avg - min_cnt) >> shift);
    if (|full[CNT_W+1:HP_W]) return '1;
    else                     return full[HP_W-1:0];
  endfunction

endpackage

// File: rtl/echo_tone_mapper_tone_gen.sv
// Square-wave generator: phase counter, half-period latch and output toggle.
// The half-period only changes on a toggle or an explicit load, so a new pitch
// never produces a shortened half-cycle.
module echo_tone_mapper_tone_gen
  import echo_tone_mapper_pkg::*;
#(
  parameter int unsigned BASE_HP = DEF_BASE_HP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable_i,
  input  logic            load_i,
  input  logic [HP_W-1:0] target_hp_i,
  output logic            audio_out_o,
  output logic [HP_W-1:0] half_period_o
);

  logic [HP_W-1:0] phase_q;
  logic [HP_W-1:0] half_q;
  logic            audio_q;

  // Phase counter, half-period latch and toggle; disable forces silence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      half_q  <= HP_W'(BASE_HP);
      audio_q <= 1'b0;
    end else if (!enable_i) begin
      phase_q <= '0;
      audio_q <= 1'b0;
    end else if (load_i) begin
      phase_q <= '0;
      half_q  <= target_hp_i;
      audio_q <= 1'b0;
    end else if (phase_q == half_q - HP_W'(1)) begin
      phase_q <= '0;
      half_q  <= target_hp_i;
      audio_q <= ~audio_q;
    end else begin
      phase_q <= phase_q + HP_W'(1);
    end
  end

  assign audio_out_o   = audio_q;
  assign half_period_o = half_q;

endmodule

// File: rtl/echo_tone_mapper.sv
// Theremin echo-count mapper: range check, 4-tap moving average, linear map
// to a half-period, and mute control on out-of-range hands or sensor stall.
//
//  state      | meaning
//  ST_MUTED   | silent, waiting for the first in-range echo
//  ST_PLAYING | tone sounding, tracking the averaged echo count
module echo_tone_mapper
  import echo_tone_mapper_pkg::*;
#(
  parameter int unsigned MIN_CNT   = DEF_MIN_CNT,
  parameter int unsigned MAX_CNT   = DEF_MAX_CNT,
  parameter int unsigned BASE_HP   = DEF_BASE_HP,
  parameter int unsigned SHIFT     = DEF_SHIFT,
  parameter int unsigned OOR_LIMIT = DEF_OOR_LIMIT,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] echo_cnt_i,
  input  logic             cnt_valid_i,
  output logic             audio_out_o,
  output logic             note_active_o,
  output logic [HP_W-1:0]  half_period_o
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned OOR_W = $clog2(OOR_LIMIT + 1);
  localparam logic [CNT_W+1:0] MIN_W  = (CNT_W+2)'(MIN_CNT);
  localparam logic [CNT_W+1:0] BASE_W = (CNT_W+2)'(BASE_HP);

  state_e                      state_q, state_d;
  logic [3:0][CNT_W-1:0]       tap_q, tap_d;
  logic [OOR_W-1:0]            oor_q, oor_d;
  logic [TO_W-1:0]             to_q, to_d;
  logic [CNT_W+1:0]            sum_q;
  logic [HP_W-1:0]             target_q;
  logic                        in_range;
  logic                        entry;
  logic [HP_W-1:0]             tone_target;

  assign in_range = cnt_valid_i
                    && (echo_cnt_i >= CNT_W'(MIN_CNT))
                    && (echo_cnt_i <= CNT_W'(MAX_CNT));

  // Next-state, window update and mute counters.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    oor_d   = oor_q;
    to_d    = to_q;
    case (state_q)
      ST_MUTED: begin
        oor_d = '0;
        to_d  = '0;
        if (in_range) begin
          state_d = ST_PLAYING;
          for (int i = 0; i < 4; i++) tap_d[i] = echo_cnt_i;
        end
      end
      ST_PLAYING: begin
        if (cnt_valid_i) begin
          // A sample on the expiry cycle clears the stall timer: no mute.
          to_d = '0;
          if (in_range) begin
            tap_d = {tap_q[2:0], echo_cnt_i};
            oor_d = '0;
          end else if (oor_q == OOR_W'(OOR_LIMIT - 1)) begin
            state_d = ST_MUTED;
            oor_d   = '0;
          end else begin
            oor_d = oor_q + OOR_W'(1);
          end
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          state_d = ST_MUTED;
          to_d    = '0;
          oor_d   = '0;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: state_d = ST_MUTED;
    endcase
  end

  // State, window and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_MUTED;
      tap_q   <= '0;
      oor_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      oor_q   <= oor_d;
      to_q    <= to_d;
    end
  end

  // Two-stage averaging pipeline: window sum, then mapped half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q    <= '0;
      target_q <= HP_W'(BASE_HP);
    end else begin
      sum_q    <= {2'b00, tap_q[0]} + {2'b00, tap_q[1]}
                + {2'b00, tap_q[2]} + {2'b00, tap_q[3]};
      target_q <= map_hp(sum_q >> 2, MIN_W, BASE_W, SHIFT);
    end
  end

  // On entry the window is all one value, so its mapping is taken directly
  // from the accepted sample instead of the stale pipeline.
  assign entry       = (state_q == ST_MUTED) && (state_d == ST_PLAYING);
  assign tone_target = entry ? map_hp({2'b00, echo_cnt_i}, MIN_W, BASE_W, SHIFT)
                             : target_q;

  echo_tone_mapper_tone_gen #(
    .BASE_HP (BASE_HP)
  ) u_tone_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (state_d == ST_PLAYING),
    .load_i        (entry),
    .target_hp_i   (tone_target),
    .audio_out_o   (audio_out_o),
    .half_period_o (half_period_o)
  );

  assign note_active_o = (state_q == ST_PLAYING);

endmodule
